// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS memory stage
//               (pipeline register layouts, memory-access FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Memory-access state: REQ while an unacknowledged memory-op sits in EX/MEM
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_t;

    // EX/MEM pipeline register contents
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] st;
        logic [REG_W-1:0]  dest;
        logic              wb_en;
        logic              memtoreg;
        logic              r_en;
        logic              w_en;
    } exmem_t;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rdata;
        logic [REG_W-1:0]  dest;
        logic              wb_en;
        logic              memtoreg;
    } memwb_t;

    // A real instruction with either memory enable set needs the data port
    function automatic logic is_mem_op(input logic valid, input logic r_en,
                                       input logic w_en);
        return valid & (r_en | w_en);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_fsm
// Description : Request/acknowledge sequencer for the data-memory port.
//               Tracks whether EX/MEM holds an outstanding memory-op and
//               generates dmem_req, dmem_we and the upstream stall.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_fsm
    import mips_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_mem_op,   // instruction about to enter EX/MEM is a memory-op
    input  logic in_write,    // ... and that memory-op is a write
    input  logic dmem_ack,
    output logic dmem_req,
    output logic dmem_we,
    output logic mem_stall
);

    mem_state_t r_state;
    logic       r_we;
    logic       w_capture;

    // An ack only counts while a request is actually outstanding
    assign mem_stall = (r_state == REQ) & ~dmem_ack;
    assign w_capture = ~mem_stall;
    assign dmem_req  = (r_state == REQ);
    assign dmem_we   = r_we;

    // State and write flag follow EX/MEM: re-evaluated on every capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
        end else if (w_capture) begin
            r_state <= in_mem_op ? REQ : IDLE;
            r_we    <= in_mem_op & in_write;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MIPS memory stage. EX/MEM and MEM/WB pipeline registers,
//               data-memory request port, write-back result mux and the
//               forwarding taps returned to the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    // execute stage
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] st_value,
    input  logic [REG_W-1:0]  dest_3,
    input  logic              wb_en_3,
    input  logic              memtoreg_3,
    input  logic              mem_r_en_3,
    input  logic              mem_w_en_3,
    output logic              mem_stall,
    // data memory
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    // forwarding / write-back
    output logic [DATA_W-1:0] alu_res_mem,
    output logic [REG_W-1:0]  dest_4,
    output logic              mem_wb_en,
    output logic [DATA_W-1:0] result_wb,
    output logic [REG_W-1:0]  dest_5,
    output logic              wb_en_5
);

    exmem_t r_exmem;
    memwb_t r_memwb;
    logic   w_in_mem_op;
    logic   w_rd_done;

    assign w_in_mem_op = is_mem_op(ex_valid, mem_r_en_3, mem_w_en_3);

    mem_access_fsm u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_mem_op (w_in_mem_op),
        .in_write  (mem_w_en_3),
        .dmem_ack  (dmem_ack),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .mem_stall (mem_stall)
    );

    // Byte offset is dropped: the port is word-addressed
    assign dmem_addr  = {r_exmem.alu[DATA_W-1:2], 2'b00};
    assign dmem_wdata = r_exmem.st;

    // A read completes on its ack; a write with both enables set discards data
    assign w_rd_done = dmem_req & dmem_ack & r_exmem.r_en & ~r_exmem.w_en;

    // EX/MEM: capture whenever the stage is not waiting on memory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exmem <= '0;
        end else if (!mem_stall) begin
            r_exmem.valid    <= ex_valid;
            r_exmem.alu      <= alu_result;
            r_exmem.st       <= st_value;
            r_exmem.dest     <= dest_3;
            r_exmem.wb_en    <= wb_en_3;
            r_exmem.memtoreg <= memtoreg_3;
            r_exmem.r_en     <= mem_r_en_3;
            r_exmem.w_en     <= mem_w_en_3;
        end
    end

    // MEM/WB: advance from EX/MEM, or insert a bubble while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_memwb <= '0;
        end else if (mem_stall) begin
            r_memwb.valid <= 1'b0;
        end else begin
            r_memwb.valid    <= r_exmem.valid;
            r_memwb.alu      <= r_exmem.alu;
            r_memwb.rdata    <= w_rd_done ? dmem_rdata : '0;
            r_memwb.dest     <= r_exmem.dest;
            r_memwb.wb_en    <= r_exmem.wb_en;
            r_memwb.memtoreg <= r_exmem.memtoreg;
        end
    end

    assign alu_res_mem = r_exmem.alu;
    assign dest_4      = r_exmem.dest;
    assign mem_wb_en   = r_exmem.valid & r_exmem.wb_en;

    assign result_wb   = r_memwb.memtoreg ? r_memwb.rdata : r_memwb.alu;
    assign dest_5      = r_memwb.dest;
    assign wb_en_5     = r_memwb.valid & r_memwb.wb_en;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import mips_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_valid;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] st_value;
    logic [REG_W-1:0]  dest_3;
    logic              wb_en_3, memtoreg_3, mem_r_en_3, mem_w_en_3;
    logic              mem_stall;
    logic              dmem_req, dmem_we;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] alu_res_mem, result_wb;
    logic [REG_W-1:0]  dest_4, dest_5;
    logic              mem_wb_en, wb_en_5;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .alu_result(alu_result), .st_value(st_value),
        .dest_3(dest_3), .wb_en_3(wb_en_3), .memtoreg_3(memtoreg_3),
        .mem_r_en_3(mem_r_en_3), .mem_w_en_3(mem_w_en_3),
        .mem_stall(mem_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .alu_res_mem(alu_res_mem), .dest_4(dest_4), .mem_wb_en(mem_wb_en),
        .result_wb(result_wb), .dest_5(dest_5), .wb_en_5(wb_en_5)
    );

    // advance one clock; inputs change and outputs are sampled 1 time unit later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] s,
                         input logic [4:0] d, input logic wb, input logic m2r,
                         input logic r, input logic w);
        ex_valid = v; alu_result = a; st_value = s; dest_3 = d;
        wb_en_3 = wb; memtoreg_3 = m2r; mem_r_en_3 = r; mem_w_en_3 = w;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        tot_cnt++; if (dmem_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", dmem_req); else pass_cnt++;
        tot_cnt++; if (mem_stall !== 1'b0) $display("FAIL rst_stall got=%b exp=0", mem_stall); else pass_cnt++;
        tot_cnt++; if ({mem_wb_en, wb_en_5} !== 2'b00) $display("FAIL rst_wben got=%b exp=00", {mem_wb_en, wb_en_5}); else pass_cnt++;
        tot_cnt++; if ({alu_res_mem, result_wb} !== 64'h0) $display("FAIL rst_data got=%h exp=0", {alu_res_mem, result_wb}); else pass_cnt++;
        tot_cnt++; if ({dest_4, dest_5} !== 10'h0) $display("FAIL rst_dest got=%h exp=0", {dest_4, dest_5}); else pass_cnt++;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_alu();
        drive(1'b1, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        tot_cnt++; if (mem_stall !== 1'b0) $display("FAIL alu_stall0 got=%b exp=0", mem_stall); else pass_cnt++;
        cyc();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        tot_cnt++; if (alu_res_mem !== 32'h1234) $display("FAIL alu_res_mem got=%h exp=1234", alu_res_mem); else pass_cnt++;
        tot_cnt++; if (dest_4 !== 5'd5) $display("FAIL alu_dest4 got=%0d exp=5", dest_4); else pass_cnt++;
        tot_cnt++; if (mem_wb_en !== 1'b1) $display("FAIL alu_mem_wb_en got=%b exp=1", mem_wb_en); else pass_cnt++;
        tot_cnt++; if ({dmem_req, mem_stall} !== 2'b00) $display("FAIL alu_noreq got=%b exp=00", {dmem_req, mem_stall}); else pass_cnt++;
        cyc();
        tot_cnt++; if (result_wb !== 32'h1234) $display("FAIL alu_result_wb got=%h exp=1234", result_wb); else pass_cnt++;
        tot_cnt++; if (dest_5 !== 5'd5) $display("FAIL alu_dest5 got=%0d exp=5", dest_5); else pass_cnt++;
        tot_cnt++; if (wb_en_5 !== 1'b1) $display("FAIL alu_wb_en_5 got=%b exp=1", wb_en_5); else pass_cnt++;
    endtask

    task automatic test_load_zero_wait();
        drive(1'b1, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        tot_cnt++; if (dmem_req !== 1'b1) $display("FAIL ld_req got=%b exp=1", dmem_req); else pass_cnt++;
        tot_cnt++; if (dmem_addr !== 32'h0000_0100) $display("FAIL ld_addr got=%h exp=00000100", dmem_addr); else pass_cnt++;
        tot_cnt++; if (dmem_we !== 1'b0) $display("FAIL ld_we got=%b exp=0", dmem_we); else pass_cnt++;
        tot_cnt++; if (mem_stall !== 1'b0) $display("FAIL ld_stall got=%b exp=0", mem_stall); else pass_cnt++;
        cyc();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        #1;
        tot_cnt++; if (result_wb !== 32'hDEAD_BEEF) $display("FAIL ld_result_wb got=%h exp=deadbeef", result_wb); else pass_cnt++;
        tot_cnt++; if ({wb_en_5, dest_5} !== {1'b1, 5'd7}) $display("FAIL ld_wb got=%b/%0d exp=1/7", wb_en_5, dest_5); else pass_cnt++;
        tot_cnt++; if (dmem_req !== 1'b0) $display("FAIL ld_req_drop got=%b exp=0", dmem_req); else pass_cnt++;
    endtask

    task automatic test_store_delayed();
        // wb_en is set on this store only so the bubbles are observable on wb_en_5
        drive(1'b1, 32'h0000_0208, 32'h55AA_55AA, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc();
        drive(1'b0, 32'h0000_0999, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            tot_cnt++; if ({dmem_req, dmem_we, mem_stall} !== 3'b111) $display("FAIL st_hold%0d req/we/stall got=%b exp=111", i, {dmem_req, dmem_we, mem_stall}); else pass_cnt++;
            tot_cnt++; if ({dmem_addr, dmem_wdata} !== {32'h0000_0208, 32'h55AA_55AA}) $display("FAIL st_hold%0d addr/wdata got=%h/%h exp=00000208/55aa55aa", i, dmem_addr, dmem_wdata); else pass_cnt++;
            tot_cnt++; if ({alu_res_mem, dest_4} !== {32'h0000_0208, 5'd9}) $display("FAIL st_exmem%0d got=%h/%0d exp=00000208/9", i, alu_res_mem, dest_4); else pass_cnt++;
            cyc();
            tot_cnt++; if (wb_en_5 !== 1'b0) $display("FAIL st_bubble%0d wb_en_5 got=%b exp=0", i, wb_en_5); else pass_cnt++;
        end
        dmem_ack = 1'b1;
        #1;
        tot_cnt++; if ({dmem_req, dmem_we, mem_stall} !== 3'b110) $display("FAIL st_ack req/we/stall got=%b exp=110", {dmem_req, dmem_we, mem_stall}); else pass_cnt++;
        cyc();
        dmem_ack = 1'b0;
        #1;
        tot_cnt++; if ({wb_en_5, result_wb} !== {1'b1, 32'h0000_0208}) $display("FAIL st_done got=%b/%h exp=1/00000208", wb_en_5, result_wb); else pass_cnt++;
        tot_cnt++; if ({dmem_req, alu_res_mem} !== {1'b0, 32'h0000_0999}) $display("FAIL st_advance got=%b/%h exp=0/00000999", dmem_req, alu_res_mem); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h0000_0300, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 32'h0000_0404, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        #1;
        tot_cnt++; if ({dmem_req, dmem_we, mem_stall} !== 3'b100) $display("FAIL b2b_ld req/we/stall got=%b exp=100", {dmem_req, dmem_we, mem_stall}); else pass_cnt++;
        tot_cnt++; if (dmem_addr !== 32'h0000_0300) $display("FAIL b2b_ld_addr got=%h exp=00000300", dmem_addr); else pass_cnt++;
        cyc();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        tot_cnt++; if ({dmem_req, dmem_we, mem_stall} !== 3'b110) $display("FAIL b2b_st req/we/stall got=%b exp=110", {dmem_req, dmem_we, mem_stall}); else pass_cnt++;
        tot_cnt++; if ({dmem_addr, dmem_wdata} !== {32'h0000_0404, 32'h1234_5678}) $display("FAIL b2b_st addr/wdata got=%h/%h exp=00000404/12345678", dmem_addr, dmem_wdata); else pass_cnt++;
        tot_cnt++; if ({wb_en_5, result_wb} !== {1'b1, 32'hCAFE_F00D}) $display("FAIL b2b_ld_wb got=%b/%h exp=1/cafef00d", wb_en_5, result_wb); else pass_cnt++;
        cyc();
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        #1;
        tot_cnt++; if (dmem_req !== 1'b0) $display("FAIL b2b_end_req got=%b exp=0", dmem_req); else pass_cnt++;
    endtask

    task automatic test_bubble();
        drive(1'b0, 32'h0000_0500, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        dmem_ack = 1'b1;   // stray ack with nothing outstanding
        #1;
        tot_cnt++; if ({dmem_req, mem_stall, mem_wb_en} !== 3'b000) $display("FAIL bub_req/stall/wben got=%b exp=000", {dmem_req, mem_stall, mem_wb_en}); else pass_cnt++;
        cyc();
        dmem_ack = 1'b0;
        tot_cnt++; if (wb_en_5 !== 1'b0) $display("FAIL bub_wb_en_5 got=%b exp=0", wb_en_5); else pass_cnt++;
    endtask

    task automatic test_reset_mid_req();
        drive(1'b1, 32'h0000_0600, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        tot_cnt++; if ({dmem_req, mem_stall, mem_wb_en} !== 3'b111) $display("FAIL mid_pre got=%b exp=111", {dmem_req, mem_stall, mem_wb_en}); else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        tot_cnt++; if ({dmem_req, mem_stall, mem_wb_en, wb_en_5} !== 4'b0000) $display("FAIL mid_rst got=%b exp=0000", {dmem_req, mem_stall, mem_wb_en, wb_en_5}); else pass_cnt++;
        cyc();
        rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;   // late ack
        #1;
        tot_cnt++; if ({dmem_req, mem_stall} !== 2'b00) $display("FAIL late_ack req/stall got=%b exp=00", {dmem_req, mem_stall}); else pass_cnt++;
        cyc();
        dmem_ack = 1'b0;
        tot_cnt++; if ({wb_en_5, result_wb} !== {1'b0, 32'h0}) $display("FAIL late_ack_wb got=%b/%h exp=0/00000000", wb_en_5, result_wb); else pass_cnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_zero_wait();
        test_store_delayed();
        test_back_to_back();
        test_bubble();
        test_reset_mid_req();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage MIPS pipeline. Holds the EX/MEM pipeline register fed by the execute stage and drives a request/acknowledge data-memory port. Produces the MEM/WB pipeline register consumed by write-back. Exports the MEM- and WB-side forwarding values (ALU_res_MEM, dest_4, MEM_WB_EN, result_WB, dest_5, WB_EN_5) back to the execute stage, and stalls upstream while a memory access is outstanding.

## Interface
- DATA_W, 32: data/address width
- REG_W, 5: register index width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous and active-low
- ex_valid  in  1  execute stage presents a real instruction (0 = bubble)
- alu_result  in  DATA_W  ALUResult from execute
- st_value  in  DATA_W  forwarded store data (ST_value_out)
- dest_3  in  REG_W  destination register
- wb_en_3, memtoreg_3, mem_r_en_3, mem_w_en_3  in  1 each  control bits
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and the EX/MEM capture
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_W  word-aligned byte address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- dmem_ack  in  1  access complete
- alu_res_mem  out  DATA_W  EX/MEM ALU result (forwarding)
- dest_4  out  REG_W  EX/MEM destination
- mem_wb_en  out  1  EX/MEM valid & wb_en
- result_wb  out  DATA_W  write-back value
- dest_5  out  REG_W  MEM/WB destination
- wb_en_5  out  1  MEM/WB valid & wb_en

## Operation
- The EX/MEM register holds valid, alu_result, st_value, dest, wb_en, memtoreg, mem_r_en and mem_w_en. It captures the execute-stage inputs on every clock where mem_stall = 0 and holds its contents otherwise.
- Memory-op = EX/MEM valid & (mem_r_en | mem_w_en). If both enables are set, the access is a write and the read data is discarded.
- The FSM has two states, IDLE and REQ. State is REQ whenever EX/MEM holds a memory-op that has not yet been acknowledged.
  - On an EX/MEM capture: next state = REQ if the incoming instruction is a memory-op, else IDLE.
  - In REQ with dmem_ack = 1: the access completes and EX/MEM advances in the same cycle.
- dmem_req = (state == REQ).
- While dmem_req = 1, dmem_addr = {alu_res[31:2], 2'b00}, dmem_we and dmem_wdata = EX/MEM st_value, and all of them stay stable until ack. Address bits [1:0] are ignored.
- mem_stall = (state == REQ) & ~dmem_ack.
- The MEM/WB register updates every cycle:
  - If mem_stall = 1, it loads a bubble (valid = 0, so wb_en_5 = 0).
  - Otherwise it loads from EX/MEM; rdata_5 = dmem_rdata when the completing access is a read.
- result_wb = memtoreg_5 ? rdata_5 : alu_5 (combinational).
- alu_res_mem carries the address for loads, not the loaded data. The load-use stall belongs to the hazard unit in decode, not to this block.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, all valids = 0, dmem_req = 0, mem_stall = 0.
  - alu_res_mem, dest_4, result_wb, dest_5 = 0; mem_wb_en = wb_en_5 = 0.
- Reset mid-access drops dmem_req immediately. A late dmem_ack arriving after reset is ignored.
- Non-memory instruction: 1 cycle in EX/MEM, visible on result_wb in the next cycle.
- Memory access acknowledged in the first REQ cycle (zero-wait): no stall, same throughput as an ALU instruction.
- Memory access acknowledged N cycles after req rises: mem_stall is high for N cycles and N bubbles enter MEM/WB.
- dmem_ack while dmem_req = 0 is ignored.
- Back-to-back memory-ops: the cycle that acknowledges the first captures the second, and state stays REQ. dmem_req remains high and address/we/wdata switch to the new op.
- ex_valid = 0 captures a bubble. A bubble never requests memory and never writes back.

## Structure
- Shared package mips_pkg holds:
  - the mem_state_t enum (IDLE, REQ);
  - the DATA_W and REG_W constants;
  - an exmem_t struct (valid, alu, st, dest, wb_en, memtoreg, r_en, w_en) and a memwb_t struct.
- Sub-module mem_access_fsm contains the state register, dmem_req, dmem_we and mem_stall generation. The top-level module holds the EX/MEM and MEM/WB registers and the result mux.

## Test plan
- Reset: assert rst_n = 0 mid-REQ → dmem_req, mem_stall, wb_en_5 and mem_wb_en = 0 in the same cycle; late ack ignored after release.
- ALU instruction: alu_result = 0x0000_1234, dest = 5, wb_en = 1 → next cycle alu_res_mem = 0x1234, dest_4 = 5, mem_wb_en = 1; cycle after that result_wb = 0x1234, dest_5 = 5, wb_en_5 = 1; no stall throughout.
- Load with zero-wait ack: addr 0x0000_0103, rdata = 0xDEAD_BEEF → dmem_addr = 0x0000_0100, dmem_we = 0, no stall; next cycle result_wb = 0xDEADBEEF.
- Store with ack delayed 3 cycles, wdata = 0x55AA_55AA → dmem_req, dmem_we and wdata held for 4 cycles; mem_stall high for 3 cycles; 3 bubbles with wb_en_5 = 0; EX/MEM unchanged during the stall.
- Back-to-back load then store, each acked immediately → dmem_req stays high across both; address/we switch on the ack cycle; no stall.
- Bubble (ex_valid = 0) with mem_r_en = 1 → dmem_req stays 0; mem_wb_en = 0; wb_en_5 = 0.
